// File: rtl/ddr_burst_pkg.sv
// Shared definitions for the DDR burst controller.
// Holds the FSM state encoding, the MIG command codes, the per-command address
// step and the burst length width.
package ddr_burst_pkg;

    typedef enum logic [2:0] {
        StIdle        = 3'd0,
        StMemRead     = 3'd1,
        StMemWrite    = 3'd2,
        StMemReadEnd  = 3'd3,
        StMemWriteEnd = 3'd4
    } state_e;

    localparam logic [2:0]  APP_CMD_WR = 3'b000;
    localparam logic [2:0]  APP_CMD_RD = 3'b001;
    localparam int unsigned ADDR_STEP  = 8;
    localparam int unsigned LEN_WIDTH  = 10;

endpackage

// File: rtl/ddr_burst_ctrl_if.sv
// MIG native application interface bundle.
// master: controller side (drives command and write data, receives ready/read data).
// slave:  memory controller side.
//   app_addr/app_cmd/app_en/app_rdy             command channel
//   app_wdf_data/app_wdf_wren/app_wdf_end/_rdy  write data channel
//   app_rd_data/app_rd_data_valid               read data channel
interface ddr_burst_ctrl_if #(
    parameter int unsigned DDR_DATA_WIDTH = 128,
    parameter int unsigned DDR_ADDR_WIDTH = 28
);
    logic [DDR_ADDR_WIDTH-1:0] app_addr;
    logic [2:0]                app_cmd;
    logic                      app_en;
    logic                      app_rdy;
    logic [DDR_DATA_WIDTH-1:0] app_wdf_data;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic                      app_wdf_rdy;
    logic [DDR_DATA_WIDTH-1:0] app_rd_data;
    logic                      app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/ddr_wdata_hold.sv
// One-entry write data hold register between the user write port and the MIG
// write data channel.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture data_i (only asserted while empty)
//   data_i       : incoming write beat
//   pop_i        : entry consumed downstream
//   valid_o      : entry occupied
//   data_o       : held beat
module ddr_wdata_hold
    import ddr_burst_pkg::*;
#(
    parameter int unsigned Width = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);
    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/ddr_burst_ctrl.sv
// Burst controller bridging a simple read/write burst user port onto the MIG
// native application interface. One command per beat, address +8 per command.
// Ports:
//   mem_clk, rst                    clock, asynchronous active-high reset
//   init_calib_complete             bursts are only granted once high
//   rd_/wr_burst_req/_len/_addr     level requests, held until the finish pulse
//   rd_burst_data_valid/_data       read beats, one cycle after the MIG
//   rd_/wr_burst_finish             one-cycle completion pulses
//   wr_burst_data_req/wr_burst_data next write beat request; data one cycle later
//   app                             MIG application interface (master side)
// Build option: define DDR_BURST_RD_PRIORITY_EN to grant reads over writes when
// both are requested; by default writes win.
module ddr_burst_ctrl
    import ddr_burst_pkg::*;
#(
    parameter int unsigned DDR_DATA_WIDTH = 128,
    parameter int unsigned DDR_ADDR_WIDTH = 28
) (
    input  logic                      mem_clk,
    input  logic                      rst,
    input  logic                      init_calib_complete,
    input  logic                      rd_burst_req,
    input  logic                      wr_burst_req,
    input  logic [LEN_WIDTH-1:0]      rd_burst_len,
    input  logic [LEN_WIDTH-1:0]      wr_burst_len,
    input  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
    output logic                      rd_burst_data_valid,
    output logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
    output logic                      rd_burst_finish,
    output logic                      wr_burst_data_req,
    input  logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
    output logic                      wr_burst_finish,
    ddr_burst_ctrl_if.master          app
);
    state_e                    state_q, state_d;
    logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      cmd_cnt_q, cmd_cnt_d;   // accepted commands
    logic [LEN_WIDTH-1:0]      xfer_cnt_q, xfer_cnt_d; // read beats in / write beats out
    logic [LEN_WIDTH-1:0]      req_cnt_q, req_cnt_d;   // write data requests issued
    logic                      req_inflight_q, req_inflight_d;
    logic                      rd_valid_q;
    logic [DDR_DATA_WIDTH-1:0] rd_data_q;

    logic                      grant_rd, grant_wr;
    logic                      cmd_active, cmd_fire, rd_beat, data_req, wdf_fire;
    logic                      hold_valid;
    logic [DDR_DATA_WIDTH-1:0] hold_data;

`ifdef DDR_BURST_RD_PRIORITY_EN
    assign grant_rd = init_calib_complete & rd_burst_req;
    assign grant_wr = init_calib_complete & wr_burst_req & ~rd_burst_req;
`else
    assign grant_wr = init_calib_complete & wr_burst_req;
    assign grant_rd = init_calib_complete & rd_burst_req & ~wr_burst_req;
`endif

    assign cmd_active = ((state_q == StMemRead) || (state_q == StMemWrite)) &&
                        (cmd_cnt_q < len_q);
    assign cmd_fire   = cmd_active & app.app_rdy;
    assign rd_beat    = (state_q == StMemRead) && app.app_rd_data_valid && (xfer_cnt_q < len_q);
    // Next beat is requested only once the previous one has landed and drained.
    assign data_req   = (state_q == StMemWrite) && !hold_valid && !req_inflight_q &&
                        (req_cnt_q < len_q);
    assign wdf_fire   = hold_valid & app.app_wdf_rdy;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        len_d          = len_q;
        cmd_cnt_d      = cmd_cnt_q;
        xfer_cnt_d     = xfer_cnt_q;
        req_cnt_d      = req_cnt_q;
        req_inflight_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_wr || grant_rd) begin
                    state_d    = grant_wr ? StMemWrite : StMemRead;
                    addr_d     = grant_wr ? wr_burst_addr : rd_burst_addr;
                    len_d      = grant_wr ? wr_burst_len : rd_burst_len;
                    cmd_cnt_d  = '0;
                    xfer_cnt_d = '0;
                    req_cnt_d  = '0;
                end
            end
            StMemRead, StMemWrite: begin
                if (cmd_fire) begin
                    addr_d    = addr_q + DDR_ADDR_WIDTH'(ADDR_STEP);
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                end
                if (rd_beat || ((state_q == StMemWrite) && wdf_fire)) begin
                    xfer_cnt_d = xfer_cnt_q + 1'b1;
                end
                if (data_req) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                req_inflight_d = data_req;
                if ((cmd_cnt_q == len_q) && (xfer_cnt_q == len_q)) begin
                    state_d = (state_q == StMemRead) ? StMemReadEnd : StMemWriteEnd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            len_q          <= '0;
            cmd_cnt_q      <= '0;
            xfer_cnt_q     <= '0;
            req_cnt_q      <= '0;
            req_inflight_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            cmd_cnt_q      <= cmd_cnt_d;
            xfer_cnt_q     <= xfer_cnt_d;
            req_cnt_q      <= req_cnt_d;
            req_inflight_q <= req_inflight_d;
            rd_valid_q     <= rd_beat;
            if (rd_beat) begin
                rd_data_q <= app.app_rd_data;
            end
        end
    end

    // Data arrives on the cycle after a request, so the request flag is the load strobe.
    ddr_wdata_hold #(
        .Width (DDR_DATA_WIDTH)
    ) u_wdata_hold (
        .clk_i   (mem_clk),
        .rst_i   (rst),
        .load_i  (req_inflight_q),
        .data_i  (wr_burst_data),
        .pop_i   (wdf_fire),
        .valid_o (hold_valid),
        .data_o  (hold_data)
    );

    assign app.app_en       = cmd_active;
    assign app.app_addr     = addr_q;
    assign app.app_cmd      = (state_q == StMemRead) ? APP_CMD_RD : APP_CMD_WR;
    assign app.app_wdf_wren = hold_valid;
    assign app.app_wdf_end  = hold_valid;
    assign app.app_wdf_data = hold_data;

    assign rd_burst_data_valid = rd_valid_q;
    assign rd_burst_data       = rd_data_q;
    assign rd_burst_finish     = (state_q == StMemReadEnd);
    assign wr_burst_finish     = (state_q == StMemWriteEnd);
    assign wr_burst_data_req   = data_req;
endmodule

// File: tb/tb_ddr_burst_ctrl.sv
module tb_ddr_burst_ctrl;
    import ddr_burst_pkg::*;

    logic         mem_clk = 1'b0;
    logic         rst;
    logic         init_calib_complete;
    logic         rd_burst_req, wr_burst_req;
    logic [9:0]   rd_burst_len, wr_burst_len;
    logic [27:0]  rd_burst_addr, wr_burst_addr;
    logic         rd_burst_data_valid;
    logic [127:0] rd_burst_data;
    logic         rd_burst_finish;
    logic         wr_burst_data_req;
    logic [127:0] wr_burst_data = '0;
    logic         wr_burst_finish;

    ddr_burst_ctrl_if #(.DDR_DATA_WIDTH(128), .DDR_ADDR_WIDTH(28)) app_if ();

    ddr_burst_ctrl #(.DDR_DATA_WIDTH(128), .DDR_ADDR_WIDTH(28)) dut (
        .mem_clk             (mem_clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .rd_burst_req        (rd_burst_req),
        .wr_burst_req        (wr_burst_req),
        .rd_burst_len        (rd_burst_len),
        .wr_burst_len        (wr_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .wr_burst_addr       (wr_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_finish     (wr_burst_finish),
        .app                 (app_if)
    );

    always #5 mem_clk = ~mem_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Logs written only by the negedge monitor; the stimulus reads them.
    logic [27:0]  cmd_addr_q[$];
    logic [2:0]   cmd_typ_q[$];
    logic [127:0] wdf_q[$];
    logic [127:0] rd_q[$];
    logic [27:0]  rsp_q[$];
    int unsigned  req_cnt = 0, rd_fin_cnt = 0, wr_fin_cnt = 0, end_mism = 0;
    logic         stray = 1'b0;

    function automatic logic [127:0] rd_pat(input logic [27:0] a);
        return 128'h5A5A_0000_0000 | {100'b0, a};
    endfunction

    // Monitor plus MIG read responder and user write data source.
    always @(negedge mem_clk) begin
        if (stray) begin
            app_if.app_rd_data_valid = 1'b1;
            app_if.app_rd_data       = 128'hDEAD;
        end else if (!rst && rsp_q.size() > 0) begin
            app_if.app_rd_data_valid = 1'b1;
            app_if.app_rd_data       = rd_pat(rsp_q.pop_front());
        end else begin
            app_if.app_rd_data_valid = 1'b0;
        end
        if (!rst) begin
            if (app_if.app_en && app_if.app_rdy) begin
                cmd_addr_q.push_back(app_if.app_addr);
                cmd_typ_q.push_back(app_if.app_cmd);
                if (app_if.app_cmd == APP_CMD_RD) rsp_q.push_back(app_if.app_addr);
            end
            if (app_if.app_wdf_wren && app_if.app_wdf_rdy) wdf_q.push_back(app_if.app_wdf_data);
            if (app_if.app_wdf_wren !== app_if.app_wdf_end) end_mism++;
            if (rd_burst_data_valid) rd_q.push_back(rd_burst_data);
            if (wr_burst_data_req) begin
                req_cnt++;
                wr_burst_data = 128'hD00 + 128'(req_cnt);
            end
            if (rd_burst_finish) rd_fin_cnt++;
            if (wr_burst_finish) wr_fin_cnt++;
        end
    end

    task automatic tick();
        @(posedge mem_clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holds each request until its finish pulse has been seen, bounded by budget.
    task automatic run_burst(input int budget);
        int unsigned rd_base, wr_base;
        int n;
        rd_base = rd_fin_cnt;
        wr_base = wr_fin_cnt;
        n = 0;
        while ((rd_burst_req || wr_burst_req) && n < budget) begin
            tick();
            n++;
            if (wr_burst_req && wr_fin_cnt != wr_base) wr_burst_req = 1'b0;
            if (rd_burst_req && rd_fin_cnt != rd_base) rd_burst_req = 1'b0;
        end
        check("burst_timeout", {127'b0, rd_burst_req | wr_burst_req}, 128'd0);
        rd_burst_req = 1'b0;
        wr_burst_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_app_en"}, {127'b0, app_if.app_en}, 128'd0);
        check({tag, "_app_addr"}, {100'b0, app_if.app_addr}, 128'd0);
        check({tag, "_app_cmd"}, {125'b0, app_if.app_cmd}, 128'd0);
        check({tag, "_wdf_wren"}, {127'b0, app_if.app_wdf_wren}, 128'd0);
        check({tag, "_wdf_data"}, app_if.app_wdf_data, 128'd0);
        check({tag, "_data_req"}, {127'b0, wr_burst_data_req}, 128'd0);
        check({tag, "_rd_valid"}, {127'b0, rd_burst_data_valid}, 128'd0);
        check({tag, "_rd_data"}, rd_burst_data, 128'd0);
        check({tag, "_fin"}, {126'b0, rd_burst_finish, wr_burst_finish}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cb, wb, rb, qb, fr, fw;
        rst = 1'b1;
        init_calib_complete = 1'b0;
        rd_burst_req = 1'b0;  wr_burst_req = 1'b0;
        rd_burst_len = '0;    wr_burst_len = '0;
        rd_burst_addr = '0;   wr_burst_addr = '0;
        app_if.app_rdy = 1'b0;
        app_if.app_wdf_rdy = 1'b0;
        app_if.app_rd_data = '0;
        app_if.app_rd_data_valid = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Not calibrated: request must be ignored.
        wr_burst_len = 10'd1; wr_burst_addr = 28'h40; wr_burst_req = 1'b1;
        tick(); tick(); tick();
        check("nocal_app_en", {127'b0, app_if.app_en}, 128'd0);
        check("nocal_data_req", {127'b0, wr_burst_data_req}, 128'd0);
        wr_burst_req = 1'b0;
        tick();
        init_calib_complete = 1'b1;
        app_if.app_rdy = 1'b1;
        app_if.app_wdf_rdy = 1'b1;
        tick();

        // Read len=4 at 0x8000.
        cb = cmd_addr_q.size(); rb = rd_q.size(); fr = int'(rd_fin_cnt);
        rd_burst_addr = 28'h0008000; rd_burst_len = 10'd4; rd_burst_req = 1'b1;
        run_burst(60);
        check("rd4_ncmd", 128'(cmd_addr_q.size() - cb), 128'd4);
        check("rd4_addr0", {100'b0, cmd_addr_q[cb]},   128'h8000);
        check("rd4_addr1", {100'b0, cmd_addr_q[cb+1]}, 128'h8008);
        check("rd4_addr2", {100'b0, cmd_addr_q[cb+2]}, 128'h8010);
        check("rd4_addr3", {100'b0, cmd_addr_q[cb+3]}, 128'h8018);
        check("rd4_cmd", {125'b0, cmd_typ_q[cb]}, 128'd1);
        check("rd4_nbeat", 128'(rd_q.size() - rb), 128'd4);
        check("rd4_beat0", rd_q[rb],   rd_pat(28'h8000));
        check("rd4_beat3", rd_q[rb+3], rd_pat(28'h8018));
        check("rd4_fin", 128'(int'(rd_fin_cnt) - fr), 128'd1);
        tick();

        // Write len=3 with wdf_rdy low for 5 cycles.
        cb = cmd_addr_q.size(); wb = wdf_q.size(); qb = int'(req_cnt); fw = int'(wr_fin_cnt);
        app_if.app_wdf_rdy = 1'b0;
        wr_burst_addr = 28'h100; wr_burst_len = 10'd3; wr_burst_req = 1'b1;
        repeat (5) tick();
        check("wr3_stall_nobeat", 128'(wdf_q.size() - wb), 128'd0);
        app_if.app_wdf_rdy = 1'b1;
        run_burst(60);
        check("wr3_nreq", 128'(int'(req_cnt) - qb), 128'd3);
        check("wr3_nbeat", 128'(wdf_q.size() - wb), 128'd3);
        check("wr3_beat0", wdf_q[wb],   128'hD00 + 128'(qb + 1));
        check("wr3_beat1", wdf_q[wb+1], 128'hD00 + 128'(qb + 2));
        check("wr3_beat2", wdf_q[wb+2], 128'hD00 + 128'(qb + 3));
        check("wr3_addr2", {100'b0, cmd_addr_q[cb+2]}, 128'h110);
        check("wr3_cmd", {125'b0, cmd_typ_q[cb]}, 128'd0);
        check("wr3_fin", 128'(int'(wr_fin_cnt) - fw), 128'd1);
        tick();

        // Empty write: finish exactly two cycles after the request.
        cb = cmd_addr_q.size(); qb = int'(req_cnt);
        wr_burst_addr = 28'h200; wr_burst_len = 10'd0; wr_burst_req = 1'b1;
        tick();
        check("wr0_fin_c1", {127'b0, wr_burst_finish}, 128'd0);
        check("wr0_app_en", {127'b0, app_if.app_en}, 128'd0);
        tick();
        check("wr0_fin_c2", {127'b0, wr_burst_finish}, 128'd1);
        wr_burst_req = 1'b0;
        tick();
        check("wr0_fin_c3", {127'b0, wr_burst_finish}, 128'd0);
        check("wr0_ncmd", 128'(cmd_addr_q.size() - cb), 128'd0);
        check("wr0_nreq", 128'(int'(req_cnt) - qb), 128'd0);
        tick();

        // Simultaneous requests.
        cb = cmd_addr_q.size(); fr = int'(rd_fin_cnt); fw = int'(wr_fin_cnt);
        rd_burst_addr = 28'h200; rd_burst_len = 10'd1;
        wr_burst_addr = 28'h300; wr_burst_len = 10'd1;
        rd_burst_req = 1'b1; wr_burst_req = 1'b1;
        run_burst(80);
`ifdef DDR_BURST_RD_PRIORITY_EN
        check("both_first_cmd", {125'b0, cmd_typ_q[cb]}, 128'd1);
        check("both_first_addr", {100'b0, cmd_addr_q[cb]}, 128'h200);
        check("both_second_cmd", {125'b0, cmd_typ_q[cb+1]}, 128'd0);
`else
        check("both_first_cmd", {125'b0, cmd_typ_q[cb]}, 128'd0);
        check("both_first_addr", {100'b0, cmd_addr_q[cb]}, 128'h300);
        check("both_second_cmd", {125'b0, cmd_typ_q[cb+1]}, 128'd1);
`endif
        check("both_fins", 128'((int'(rd_fin_cnt) - fr) + (int'(wr_fin_cnt) - fw)), 128'd2);
        tick();

        // Address wrap, with command stalled for a few cycles.
        cb = cmd_addr_q.size(); rb = rd_q.size();
        app_if.app_rdy = 1'b0;
        rd_burst_addr = 28'hFFFFFF8; rd_burst_len = 10'd2; rd_burst_req = 1'b1;
        tick(); tick(); tick();
        check("wrap_en_held", {127'b0, app_if.app_en}, 128'd1);
        check("wrap_addr_held", {100'b0, app_if.app_addr}, 128'hFFFFFF8);
        app_if.app_rdy = 1'b1;
        run_burst(60);
        check("wrap_addr0", {100'b0, cmd_addr_q[cb]},   128'hFFFFFF8);
        check("wrap_addr1", {100'b0, cmd_addr_q[cb+1]}, 128'h0000000);
        check("wrap_beat1", rd_q[rb+1], rd_pat(28'h0));
        tick();

        // Stray read data while idle must not be forwarded.
        stray = 1'b1;
        tick(); tick();
        check("stray_rd_valid", {127'b0, rd_burst_data_valid}, 128'd0);
        stray = 1'b0;
        tick();

        // Reset in the middle of a write burst.
        app_if.app_rdy = 1'b0; app_if.app_wdf_rdy = 1'b0;
        wr_burst_addr = 28'h400; wr_burst_len = 10'd4; wr_burst_req = 1'b1;
        repeat (4) tick();
        check("mid_app_en", {127'b0, app_if.app_en}, 128'd1);
        check("mid_wren", {127'b0, app_if.app_wdf_wren}, 128'd1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        wr_burst_req = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        check("post_rst_app_en", {127'b0, app_if.app_en}, 128'd0);
        check("post_rst_data_req", {127'b0, wr_burst_data_req}, 128'd0);

        check("wdf_end_eq_wren", 128'(end_mism), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr_burst_ctrl.md
DDR_BURST_CTRL -- requirements
Module: ddr_burst_ctrl
Interface
REQ-001 SHALL have parameter DDR_DATA_WIDTH, default 128, width of burst and app data buses.
REQ-002 SHALL have parameter DDR_ADDR_WIDTH, default 28, width of burst and app addresses.
REQ-003 SHALL have port mem_clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port init_calib_complete  in  1  DDR calibrated; no burst accepted while low.
REQ-006 SHALL have port rd_burst_req  in  1  read burst request, level, held until rd_burst_finish.
REQ-007 SHALL have port wr_burst_req  in  1  write burst request, level, held until wr_burst_finish.
REQ-008 SHALL have port rd_burst_len  in  10  read beats.
REQ-009 SHALL have port wr_burst_len  in  10  write beats.
REQ-010 SHALL have port rd_burst_addr  in  DDR_ADDR_WIDTH  read start address.
REQ-011 SHALL have port wr_burst_addr  in  DDR_ADDR_WIDTH  write start address.
REQ-012 SHALL have port rd_burst_data_valid  out  1  rd_burst_data valid this cycle.
REQ-013 SHALL have port rd_burst_data  out  DDR_DATA_WIDTH  read beat.
REQ-014 SHALL have port rd_burst_finish  out  1  one-cycle pulse, read burst done.
REQ-015 SHALL have port wr_burst_data_req  out  1  one-cycle pulse requesting next write beat.
REQ-016 SHALL have port wr_burst_data  in  DDR_DATA_WIDTH  write beat, valid cycle after wr_burst_data_req.
REQ-017 SHALL have port wr_burst_finish  out  1  one-cycle pulse, write burst done.
REQ-018 SHALL have port app_addr  out  DDR_ADDR_WIDTH  MIG command address.
REQ-019 SHALL have port app_cmd  out  3  MIG command, write 3'b000, read 3'b001.
REQ-020 SHALL have port app_en  out  1  MIG command valid.
REQ-021 SHALL have port app_rdy  in  1  MIG command accepted when high with app_en.
REQ-022 SHALL have port app_wdf_data  out  DDR_DATA_WIDTH  MIG write data.
REQ-023 SHALL have port app_wdf_wren  out  1  MIG write data valid.
REQ-024 SHALL have port app_wdf_end  out  1  equal to app_wdf_wren (one beat per command).
REQ-025 SHALL have port app_wdf_rdy  in  1  MIG write data accepted when high with app_wdf_wren.
REQ-026 SHALL have port app_rd_data  in  DDR_DATA_WIDTH  MIG read data.
REQ-027 SHALL have port app_rd_data_valid  in  1  MIG read data valid.
Function
REQ-028 SHALL implement FSM IDLE, MEM_READ, MEM_WRITE, MEM_READ_END, MEM_WRITE_END; END states last one cycle then return to IDLE.
REQ-029 SHALL leave IDLE only when init_calib_complete=1; latch addr/len of the granted request; with both requests high, write wins (see REQ-039).
REQ-030 SHALL in MEM_READ issue len commands, app_addr starting at latched address, +8 per accepted command (app_en&app_rdy), modulo 2^DDR_ADDR_WIDTH; app_en held until accepted.
REQ-031 SHALL forward app_rd_data/app_rd_data_valid to rd_burst_data/rd_burst_data_valid registered, one-cycle latency; count beats; enter MEM_READ_END after beat len.
REQ-032 SHALL in MEM_WRITE pulse wr_burst_data_req only when one-entry hold register is empty and no request is in flight; capture wr_burst_data on the following edge; drive app_wdf_wren from hold valid until app_wdf_rdy.
REQ-033 SHALL issue write commands independently of data, same addressing as REQ-030; enter MEM_WRITE_END when len commands and len data beats are accepted.
REQ-034 SHALL pulse rd_burst_finish/wr_burst_finish exactly in MEM_READ_END/MEM_WRITE_END.
REQ-035 SHALL treat len=0 as empty burst: no app traffic, no data_req, direct to END state, finish pulse.
REQ-036 SHALL ignore app_rd_data_valid outside MEM_READ and ignore request changes mid-burst.
Reset
REQ-037 SHALL on rst clear state to IDLE, all counters, hold register and all outputs to 0 immediately, abandoning any burst in progress.
Configuration
REQ-038 SHALL, with macro DDR_BURST_RD_PRIORITY_EN defined, grant read when both requests are high in IDLE.
REQ-039 SHALL, without DDR_BURST_RD_PRIORITY_EN, grant write when both requests are high.
Structure
REQ-040 SHALL place state encoding, APP_CMD_WR, APP_CMD_RD and ADDR_STEP=8 in shared package ddr_burst_pkg.
REQ-041 SHALL implement the write hold register as sub-module ddr_wdata_hold.
Verification
REQ-042 SHALL cover: read len=4 addr 0x0008000, app_rdy=1 -> app_addr 0x8000,0x8008,0x8010,0x8018; 4 valid beats; one finish pulse.
REQ-043 SHALL cover: write len=3 with app_wdf_rdy low 5 cycles -> exactly 3 data_req pulses, 3 wdf beats in order, wr_burst_finish once.
REQ-044 SHALL cover: len=0 write -> no app_en, no data_req, wr_burst_finish 2 cycles after request.
REQ-045 SHALL cover: rd and wr requested same cycle -> write first by default, read first with DDR_BURST_RD_PRIORITY_EN.
REQ-046 SHALL cover: read at addr 0xFFFFFF8 len=2 -> second app_addr 0x0000000; and rst mid-burst -> all outputs 0, IDLE.
